// File: rtl/adv_pkg.sv
// Shared adventure-game types: move directions, arbiter states and the
// fixed-priority pick used when several buttons settle on the same edge.
package adv_pkg;

    typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;

    typedef enum logic {ARMED, LOCKED} arb_state_t;

    localparam int NUM_DIRS = 4;

    // Rise vector is indexed by dir_t (bit 0 = north). Priority is N > S > E > W.
    function automatic dir_t pick_dir(input logic [NUM_DIRS-1:0] rise);
        if (rise[DIR_N]) begin
            return DIR_N;
        end else if (rise[DIR_S]) begin
            return DIR_S;
        end else if (rise[DIR_E]) begin
            return DIR_E;
        end
        return DIR_W;
    endfunction

endpackage

// File: rtl/dir_input_conditioner_if.sv
// Button-side and move-side signals of the direction input conditioner.
// The master drives the raw buttons and consumes the moves; the slave is the
// conditioner itself.
interface dir_input_conditioner_if #(
    parameter int MOVE_W = 8
);
    logic              btn_n;
    logic              btn_s;
    logic              btn_e;
    logic              btn_w;
    logic              n;
    logic              s;
    logic              e;
    logic              w;
    logic              busy;
    logic [MOVE_W-1:0] moves;

    modport master (
        output btn_n, btn_s, btn_e, btn_w,
        input  n, s, e, w, busy, moves
    );

    modport slave (
        input  btn_n, btn_s, btn_e, btn_w,
        output n, s, e, w, busy, moves
    );
endinterface

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchroniser, consecutive-mismatch counter,
// debounced level and a one-cycle flag marking a debounced rising edge.
// quiet reports that neither synchroniser stage nor the level holds a press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic R_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic quiet
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise the raw button and accept a new level only after it has
    // disagreed with the current level on DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clock) begin
        if (!R_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != stable) begin
                if (cnt == LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    rise   <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign quiet = !sync1 && !sync2 && !stable;

endmodule

// File: rtl/dir_input_conditioner.sv
// Turns four bouncing direction buttons into single-cycle, mutually exclusive
// move pulses. After a move (and after reset) the arbiter stays locked until
// every button has been seen fully released on two consecutive edges, so a
// button held through reset, or pressed while another is held, never moves.
module dir_input_conditioner
    import adv_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MOVE_W          = 8
) (
    input  logic                   clock,
    input  logic                   R_n,
    dir_input_conditioner_if.slave bus
);

    localparam logic [MOVE_W-1:0] MOVES_MAX = '1;

    logic [NUM_DIRS-1:0] raw;
    logic [NUM_DIRS-1:0] stable;
    logic [NUM_DIRS-1:0] rise;
    logic [NUM_DIRS-1:0] quiet;
    logic                all_quiet;
    logic                settled;
    arb_state_t          state;
    logic [NUM_DIRS-1:0] pulse_q;
    logic                busy_q;
    logic [MOVE_W-1:0]   moves_q;

    assign raw = {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n};

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clock  (clock),
            .R_n    (R_n),
            .raw    (raw[i]),
            .stable (stable[i]),
            .rise   (rise[i]),
            .quiet  (quiet[i])
        );
    end

    assign all_quiet = &quiet;

    // Arbiter: one pulse per press while armed, then locked until a clean
    // all-released interval; also registers busy and the saturating count.
    always_ff @(posedge clock) begin
        if (!R_n) begin
            state   <= LOCKED;
            pulse_q <= '0;
            busy_q  <= 1'b0;
            moves_q <= '0;
            settled <= 1'b0;
        end else begin
            pulse_q <= '0;
            busy_q  <= |stable;
            settled <= all_quiet;
            case (state)
                ARMED: begin
                    if (|rise) begin
                        pulse_q <= NUM_DIRS'(1) << pick_dir(rise);
                        if (moves_q != MOVES_MAX) begin
                            moves_q <= moves_q + 1'b1;
                        end
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (all_quiet && settled) begin
                        state <= ARMED;
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

    assign bus.n     = pulse_q[DIR_N];
    assign bus.s     = pulse_q[DIR_S];
    assign bus.e     = pulse_q[DIR_E];
    assign bus.w     = pulse_q[DIR_W];
    assign bus.busy  = busy_q;
    assign bus.moves = moves_q;

endmodule
